// File: rtl/riscv_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, decoder hand-off and redirect.
// The fetch unit uses the master view; the surrounding pipeline/memory uses the slave view.
interface riscv_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/riscv_fetch.sv
// Instruction fetch front end: PC generation, credit-limited imem requests, PC-tagged buffering.
// Optional sticky trap on misaligned redirect target: define RISCV_FETCH_MISALIGN_TRAP_EN.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  riscv_fetch_if.master bus
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
  ,
  output logic          misalign_o
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t           state, state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      inst_mem  [FIFO_DEPTH];
  logic [31:0]      tag_mem   [FIFO_DEPTH];
  logic [31:0]      shadow_pc [FIFO_DEPTH];
  logic [PTR_W-1:0] head_ptr, tail_ptr, sh_head, sh_tail;
  logic [CNT_W-1:0] fifo_count, outstanding, discard;
  logic [CNT_W-1:0] outstanding_next, discard_next;
  logic [31:0]      redirect_target, rsp_tag;
  logic             flush, halt, credit_ok, req_valid, req_fire;
  logic             drop, push, pop, inst_valid;

`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
  logic misalign;
  assign halt       = misalign;
  assign misalign_o = misalign;
`else
  logic unused_pc_bits;
  assign halt           = 1'b0;
  assign unused_pc_bits = ^bus.redirect_pc[1:0];
`endif
  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

  // Credit: in-flight plus buffered words never exceed the buffer, so a response always has a slot.
  assign flush     = bus.redirect_valid;
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W;
  assign req_valid = !rst && !flush && !halt && credit_ok;
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign drop       = bus.imem_rsp_valid && (flush || state == DRAIN);
  assign push       = bus.imem_rsp_valid && !drop;
  assign inst_valid = fifo_count != '0;
  assign pop        = inst_valid && bus.inst_ready && !flush;

  // A response with nothing previously outstanding belongs to this cycle's request.
  assign rsp_tag = (outstanding == '0) ? fetch_pc : shadow_pc[sh_head];

  assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst           = inst_valid ? inst_mem[head_ptr] : '0;
  assign bus.inst_pc        = inst_valid ? tag_mem[head_ptr]  : '0;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next   = state;
    discard_next = discard;
    if (flush) begin
      discard_next = outstanding_next;
      state_next   = (outstanding_next != '0) ? DRAIN : RUN;
    end else if (bus.imem_rsp_valid && state == DRAIN) begin
      discard_next = discard - CNT_W'(1);
      if (discard == CNT_W'(1)) state_next = RUN;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      head_ptr    <= '0;
      tail_ptr    <= '0;
      sh_head     <= '0;
      sh_tail     <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_next;
      discard     <= discard_next;
      outstanding <= outstanding_next;
      if (req_fire)           sh_tail <= sh_tail + PTR_W'(1);
      if (bus.imem_rsp_valid) sh_head <= sh_head + PTR_W'(1);
      if (flush) begin
        fetch_pc   <= redirect_target;
        head_ptr   <= '0;
        tail_ptr   <= '0;
        fifo_count <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     tail_ptr <= tail_ptr + PTR_W'(1);
        if (pop)      head_ptr <= head_ptr + PTR_W'(1);
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: storage arrays are not reset; pointers and counts alone say which entries are live.
  always_ff @(posedge clk) begin
    if (req_fire) shadow_pc[sh_tail] <= fetch_pc;
    if (push) begin
      inst_mem[tail_ptr] <= bus.imem_rsp_data;
      tag_mem[tail_ptr]  <= rsp_tag;
    end
  end

`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)                                          misalign <= 1'b0;
    else if (flush && bus.redirect_pc[1:0] != 2'b00)  misalign <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_riscv_fetch.sv
// Self-checking bench for riscv_fetch: queue-level reference model, in-order memory model,
// per-cycle output comparison plus literal checks of addresses, PC tags and latency.
`timescale 1ns/1ps
module tb_riscv_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_fetch_if bus();
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
  logic misalign_o;
`endif

  riscv_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o(misalign_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: expected fetch PC, accepted-but-unanswered addresses, visible buffer.
  typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;
  ent_t        expq[$];
  logic [31:0] m_addrq[$];
  logic [31:0] m_fetch_pc;
  int          m_discard;
  bit          m_live = 1'b0;
  bit          m_halt = 1'b0;

  function automatic bit model_req();
    return !rst && !bus.redirect_valid && !m_halt && (m_addrq.size() + expq.size() < DEPTH);
  endfunction

  initial forever begin
    bit          acc;
    logic [31:0] rpc;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_live = 1'b1;
      expq.delete();
      m_addrq.delete();
      m_discard  = 0;
      m_fetch_pc = RESET_PC;
      m_halt     = 1'b0;
    end else if (m_live) begin
      acc = model_req() && bus.imem_req_ready;
      rpc = '0;
      if (bus.imem_rsp_valid) begin
        if (m_addrq.size() == 0) check("rsp_without_request", 32'd1, 32'd0);
        else rpc = m_addrq.pop_front();
      end
      if (acc) begin
        m_addrq.push_back(m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (bus.redirect_valid) begin
        expq.delete();
        m_discard  = m_addrq.size();
        m_fetch_pc = {bus.redirect_pc[31:2], 2'b00};
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
        if (bus.redirect_pc[1:0] != 2'b00) m_halt = 1'b1;
`endif
      end else begin
        if (expq.size() != 0 && bus.inst_ready) expq.delete(0);
        if (bus.imem_rsp_valid) begin
          if (m_discard > 0) m_discard--;
          else expq.push_back('{rpc, mem_word(rpc)});
        end
      end
    end
  end

  // Compare process plus logs of accepted request addresses and delivered PCs.
  logic [31:0] alog[$];
  logic [31:0] dlog[$];
  int first_req_cyc  = -1;
  int first_inst_cyc = -1;

  initial forever begin
    bit exp_req;
    @(negedge clk);
    if (m_live) begin
      exp_req = model_req();
      check("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
      if (exp_req) check("req_addr", bus.imem_req_addr, m_fetch_pc);
      check("inst_valid", 32'(bus.inst_valid), 32'(expq.size() != 0));
      if (expq.size() != 0) begin
        check("inst", bus.inst, expq[0].word);
        check("inst_pc", bus.inst_pc, expq[0].pc);
      end else begin
        check("inst_idle", bus.inst, 32'd0);
        check("inst_pc_idle", bus.inst_pc, 32'd0);
      end
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
      check("misalign_o", 32'(misalign_o), 32'(m_halt));
`endif
      if (rst) begin
        first_req_cyc  = -1;
        first_inst_cyc = -1;
      end else begin
        if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready) alog.push_back(bus.imem_req_addr);
        if (bus.inst_valid === 1'b1 && bus.inst_ready && !bus.redirect_valid)
          dlog.push_back(bus.inst_pc);
        if (first_req_cyc < 0 && bus.imem_req_valid === 1'b1) first_req_cyc = cyc;
        if (first_inst_cyc < 0 && bus.inst_valid === 1'b1) first_inst_cyc = cyc;
      end
    end
  end

  // In-order instruction memory with programmable latency; reset alongside the DUT.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t memq[$];
  int    mem_lat = 1;

  initial begin
    bit          acc_s, rst_s;
    logic [31:0] addr_s;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      acc_s  = (bus.imem_req_valid === 1'b1) && bus.imem_req_ready;
      addr_s = bus.imem_req_addr;
      rst_s  = (rst !== 1'b0);
      @(posedge clk);
      #1;
      if (rst_s) memq.delete();
      else begin
        if (bus.imem_rsp_valid && memq.size() != 0) memq.delete(0);
        if (acc_s) memq.push_back('{addr_s, cyc + mem_lat - 1});
      end
      if (memq.size() != 0 && memq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(memq[0].addr);
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_log(input string name, input bit delivered, input int idx,
                           input logic [31:0] exp);
    logic [31:0] act;
    act = 'x;
    if (delivered && idx < dlog.size()) act = dlog[idx];
    if (!delivered && idx < alog.size()) act = alog[idx];
    check(name, act, exp);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick(1);
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, a0, dm, am, bad;
    bit hit;
    rst                = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick(3);

    // Reset release, 1-cycle memory: sequential addresses and tags, 2-cycle first-inst latency.
    d0 = dlog.size();
    a0 = alog.size();
    rst = 1'b0;
    tick(12);
    check("first_inst_latency", 32'(first_inst_cyc - first_req_cyc), 32'd2);
    check_log("req_addr_0", 1'b0, a0,     32'h0);
    check_log("req_addr_1", 1'b0, a0 + 1, 32'h4);
    check_log("req_addr_2", 1'b0, a0 + 2, 32'h8);
    check_log("inst_pc_0",  1'b1, d0,     32'h0);
    check_log("inst_pc_1",  1'b1, d0 + 1, 32'h4);
    check_log("inst_pc_2",  1'b1, d0 + 2, 32'h8);

    // Decoder stall: credit caps requests, nothing delivered, resume in order with no gaps.
    mem_lat        = 2;
    bus.inst_ready = 1'b0;
    dm = dlog.size();
    tick(10);
    check("stall_no_delivery", 32'(dlog.size() - dm), 32'd0);
    check("stall_req_blocked", 32'(bus.imem_req_valid), 32'd0);
    check("stall_inst_held", 32'(bus.inst_valid), 32'd1);
    bus.inst_ready = 1'b1;
    tick(12);
    check("stall_resumed", 32'(dlog.size() - dm >= 4), 32'd1);
    bad = 0;
    for (int i = d0 + 1; i < dlog.size(); i++)
      if (dlog[i] !== dlog[i-1] + 32'd4) bad++;
    check("in_order_no_gaps", 32'(bad), 32'd0);

    // Redirect with two fetches in flight.
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_addrq.size() == 2) hit = 1'b1;
      else tick(1);
    end
    check("two_in_flight_reached", 32'(hit), 32'd1);
    dm = dlog.size();
    redirect(32'h0000_0100);
    check("redirect_clears_inst_valid", 32'(bus.inst_valid), 32'd0);
    tick(12);
    check_log("redirect_first_pc", 1'b1, dm, 32'h0000_0100);

    // Redirect coinciding with a response and a decoder pop.
    mem_lat = 1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (bus.imem_rsp_valid === 1'b1 && bus.inst_valid === 1'b1) hit = 1'b1;
      else tick(1);
    end
    check("rsp_and_pop_reached", 32'(hit), 32'd1);
    dm = dlog.size();
    am = alog.size();
    redirect(32'h0000_0200);
    check("collide_fifo_empty", 32'(bus.inst_valid), 32'd0);
    tick(10);
    check_log("collide_next_req", 1'b0, am, 32'h0000_0200);
    check_log("collide_next_inst", 1'b1, dm, 32'h0000_0200);

    // Mid-run reset with a redirect held during reset: the redirect is ignored.
    rst                = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0500;
    tick(2);
    bus.redirect_valid = 1'b0;
    tick(1);
    am  = alog.size();
    rst = 1'b0;
    tick(4);
    check_log("reset_ignores_redirect", 1'b0, am, RESET_PC);

    // Address wrap with a toggling request-ready.
    dm = dlog.size();
    am = alog.size();
    redirect(32'hFFFF_FFF8);
    for (int i = 0; i < 16; i++) begin
      bus.imem_req_ready = i[0];
      tick(1);
    end
    bus.imem_req_ready = 1'b1;
    tick(4);
    check_log("wrap_req_0",  1'b0, am,     32'hFFFF_FFF8);
    check_log("wrap_req_1",  1'b0, am + 1, 32'hFFFF_FFFC);
    check_log("wrap_req_2",  1'b0, am + 2, 32'h0000_0000);
    check_log("wrap_inst_0", 1'b1, dm,     32'hFFFF_FFF8);
    check_log("wrap_inst_1", 1'b1, dm + 1, 32'hFFFF_FFFC);
    check_log("wrap_inst_2", 1'b1, dm + 2, 32'h0000_0000);
    check_log("wrap_inst_3", 1'b1, dm + 3, 32'h0000_0004);

    // Misaligned redirect target.
    dm = dlog.size();
    redirect(32'h0000_0102);
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
    check("misalign_set", 32'(misalign_o), 32'd1);
    tick(8);
    check("misalign_sticky", 32'(misalign_o), 32'd1);
    check("misalign_fetch_stopped", 32'(bus.imem_req_valid), 32'd0);
    check("misalign_no_delivery", 32'(dlog.size() - dm), 32'd0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("misalign_cleared", 32'(misalign_o), 32'd0);
    check("fetch_restarts", 32'(bus.imem_req_valid), 32'd1);
    tick(6);
`else
    tick(10);
    check_log("misalign_forced_aligned", 1'b1, dm, 32'h0000_0100);
    check_log("misalign_continues", 1'b1, dm + 1, 32'h0000_0104);
`endif

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
